// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: four nibble passes through a shared
// 4x4 array multiplier, shift-accumulated into a 16-bit product behind valid/ready handshakes.
module mult8_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        abort,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(MUL_LAT);

    state_t      state;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] acc;
    logic [1:0]  step;
    logic [1:0]  wait_cnt;

    logic [15:0] term;
    logic [15:0] acc_next;
    logic [1:0]  step_next;
    logic [3:0]  nib_a_next;
    logic [3:0]  nib_b_next;
    logic        in_hs;
    logic        out_hs;

    // Step 1 pairs a-low with b-high and step 2 a-high with b-low, so step bit 1
    // picks the multiplicand nibble and step bit 0 the multiplier nibble.
    always_comb begin
        term = 16'h0000;
        case (step)
            2'd0:    term = {8'h00, mul_p};
            2'd1:    term = {4'h0, mul_p, 4'h0};
            2'd2:    term = {4'h0, mul_p, 4'h0};
            default: term = {mul_p, 8'h00};
        endcase
        acc_next   = acc + term;
        step_next  = step + 2'd1;
        nib_a_next = step_next[1] ? op_a[7:4] : op_a[3:0];
        nib_b_next = step_next[0] ? op_b[7:4] : op_b[3:0];
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state != IDLE);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            acc       <= 16'h0000;
            step      <= 2'd0;
            wait_cnt  <= 2'd0;
            mul_a     <= 4'h0;
            mul_b     <= 4'h0;
            out_valid <= 1'b0;
            product   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        op_a     <= a;
                        op_b     <= b;
                        acc      <= 16'h0000;
                        step     <= 2'd0;
                        wait_cnt <= 2'd0;
                        mul_a    <= a[3:0];
                        mul_b    <= b[3:0];
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        acc      <= 16'h0000;
                        step     <= 2'd0;
                        wait_cnt <= 2'd0;
                        mul_a    <= 4'h0;
                        mul_b    <= 4'h0;
                        state    <= IDLE;
                    end else if (wait_cnt == LAT) begin
                        acc      <= acc_next;
                        wait_cnt <= 2'd0;
                        if (step == 2'd3) begin
                            step      <= 2'd0;
                            mul_a     <= 4'h0;
                            mul_b     <= 4'h0;
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            step  <= step_next;
                            mul_a <= nib_a_next;
                            mul_b <= nib_b_next;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        if (in_hs) begin
                            op_a     <= a;
                            op_b     <= b;
                            acc      <= 16'h0000;
                            step     <= 2'd0;
                            wait_cnt <= 2'd0;
                            mul_a    <= a[3:0];
                            mul_b    <= b[3:0];
                            state    <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: one instance with a combinational multiplier
// and one with a two-cycle pipelined multiplier, both modelled here.
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
    logic [7:0]  a, b, mul_p;
    logic [3:0]  mul_a, mul_b;
    logic [15:0] product;

    logic        in_valid2, in_ready2, abort2, out_valid2, out_ready2, busy2;
    logic [7:0]  a2, b2, mul_p2;
    logic [3:0]  mul_a2, mul_b2;
    logic [15:0] product2;
    logic [7:0]  p_d1 = 8'h00;
    logic [7:0]  p_d2 = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    assign mul_p = 8'(mul_a) * 8'(mul_b);

    always @(posedge clk) begin
        p_d1 <= 8'(mul_a2) * 8'(mul_b2);
        p_d2 <= p_d1;
    end
    assign mul_p2 = p_d2;

    mult8_seq_ctrl #(.MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .abort(abort), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    mult8_seq_ctrl #(.MUL_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .abort(abort2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
        .out_valid(out_valid2), .out_ready(out_ready2), .product(product2), .busy(busy2)
    );

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one operation, optionally stall the consumer in DONE, then drain the result.
    task automatic apply_stimulus(input logic [7:0] ta, input logic [7:0] tb_in,
                                  input int stall, output logic [15:0] prod,
                                  output int lat);
        int guard;
        logic busy_ok;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) check_output("in_ready_timeout", 32'(in_ready), 32'd1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_in;
        tick();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!out_valid) check_output("out_valid_timeout", 32'(out_valid), 32'd1);
        check_output("busy_during_op", 32'(busy_ok && busy), 32'd1);
        prod = product;
        for (int k = 0; k < stall; k++) begin
            tick();
            check_output("stall_product_stable", 32'(product), 32'(prod));
            check_output("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_output("drained_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] prod;
        int          lat;
        logic [7:0]  exp_p[4];
        logic [7:0]  ra, rb;
        logic        seen;

        in_valid = 0; a = 0; b = 0; abort = 0; out_ready = 1;
        in_valid2 = 0; a2 = 0; b2 = 0; abort2 = 0; out_ready2 = 1;
        rst = 1'b1;
        tick();
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_product", 32'(product), 32'd0);
        check_output("reset_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        vecs[0] = '{8'hA7, 8'h3C, 16'h2724};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hC3, 16'h0000};
        vecs[3] = '{8'h12, 8'h34, 16'h03A8};
        vecs[4] = '{8'h55, 8'h55, 16'h1C39};
        vecs[5] = '{8'h01, 8'h00, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].va, vecs[i].vb, 0, prod, lat);
            check_output($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].vp));
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
        end

        // Partial-product sequence seen on the shared multiplier for 0xA7 * 0x3C.
        exp_p = '{8'h54, 8'h15, 8'h78, 8'h1E};
        in_valid = 1; a = 8'hA7; b = 8'h3C;
        tick();
        in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("mul_p_step%0d", k), 32'(mul_p), 32'(exp_p[k]));
            tick();
        end
        check_output("seq_product", 32'(product), 32'h2724);
        tick();

        // Consumer stalls for ten cycles while a new request waits.
        out_ready = 0; in_valid = 1; a = 8'hFF; b = 8'hFF;
        tick();
        a = 8'h12; b = 8'h34;
        for (int k = 0; k < 4; k++) tick();
        check_output("hold_out_valid_rise", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check_output("hold_product", 32'(product), 32'hFE01);
            check_output("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check_output("hold_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1;
        tick();
        in_valid = 0;
        check_output("b2b_out_valid_drop", 32'(out_valid), 32'd0);
        check_output("b2b_busy", 32'(busy), 32'd1);
        check_output("b2b_mul_ab", 32'({mul_a, mul_b}), 32'h24);
        for (int k = 0; k < 4; k++) tick();
        check_output("b2b_valid", 32'(out_valid), 32'd1);
        check_output("b2b_product", 32'(product), 32'h03A8);
        tick();

        // Abort during step 2.
        in_valid = 1; a = 8'h55; b = 8'h55;
        tick();
        in_valid = 0;
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        check_output("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen = 1;
            tick();
        end
        check_output("abort_no_out_valid", 32'(seen), 32'd0);
        apply_stimulus(8'h03, 8'h05, 0, prod, lat);
        check_output("post_abort_product", 32'(prod), 32'h000F);

        // Asynchronous reset in the middle of a RUN cycle.
        in_valid = 1; a = 8'hC7; b = 8'h9B;
        tick();
        in_valid = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_busy", 32'(busy), 32'd0);
        check_output("async_rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        check_output("async_rst_product", 32'(product), 32'd0);
        check_output("async_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check_output("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_output("post_rst_out_valid", 32'(out_valid), 32'd0);
        apply_stimulus(8'h10, 8'h10, 0, prod, lat);
        check_output("post_rst_product", 32'(prod), 32'h0100);

        // Randomized operands and consumer stalls against plain arithmetic.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            apply_stimulus(ra, rb, int'($urandom_range(0, 3)), prod, lat);
            check_output($sformatf("rand%0d_product", i), 32'(prod), 32'(16'(ra) * 16'(rb)));
            check_output($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
        end

        // Pipelined multiplier: each nibble pair held three cycles, result at +13.
        in_valid2 = 1; a2 = 8'hA7; b2 = 8'h3C;
        tick();
        in_valid2 = 0; a2 = 8'h00; b2 = 8'h00;
        for (int k = 0; k < 12; k++) begin
            int s;
            logic [3:0] ea, eb;
            s  = k / 3;
            ea = (s >= 2) ? 4'hA : 4'h7;
            eb = (s % 2 == 1) ? 4'h3 : 4'hC;
            check_output($sformatf("lat2_mul_ab_c%0d", k + 1), 32'({mul_a2, mul_b2}), 32'({ea, eb}));
            check_output($sformatf("lat2_no_valid_c%0d", k + 1), 32'(out_valid2), 32'd0);
            tick();
        end
        check_output("lat2_out_valid", 32'(out_valid2), 32'd1);
        check_output("lat2_product", 32'(product2), 32'h2724);
        tick();
        check_output("lat2_drained", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
